// File: rtl/dt_pkg.sv
// rtl/dt_pkg.sv - shared types and sizes for the DT result-RAM access path
package dt_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;
  localparam int IMG_W  = 128;

  typedef enum logic {
    TAG_A = 1'b0,
    TAG_B = 1'b1
  } tag_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    tag_t              tag;
  } res_cmd_t;

  function automatic tag_t other_tag(input tag_t t);
    return (t == TAG_A) ? TAG_B : TAG_A;
  endfunction

endpackage

// File: rtl/dt_rr_arb2.sv
// rtl/dt_rr_arb2.sv - two-way winner select with last-grant memory
module dt_rr_arb2
  import dt_pkg::*;
#(
  parameter int PRIO_MODE = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic a_req,
  input  logic b_req,
  output logic a_gnt,
  output logic b_gnt
);

  tag_t last_grant;
  logic a_win;

  always_comb begin
    a_win = a_req;
    if (a_req && b_req) begin
      if (PRIO_MODE == 1) begin
        a_win = 1'b1;
      end else begin
        a_win = (other_tag(last_grant) == TAG_A);
      end
    end
    // Grants are held low for the whole reset assertion, not just at the edge.
    a_gnt = reset & a_req & a_win;
    b_gnt = reset & b_req & ~a_win;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= TAG_B;
    end else if (a_gnt) begin
      last_grant <= TAG_A;
    end else if (b_gnt) begin
      last_grant <= TAG_B;
    end
  end

endmodule

// File: rtl/dt_res_arbiter.sv
// rtl/dt_res_arbiter.sv - arbitrates loader and window engine onto the result RAM
module dt_res_arbiter #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 8,
  parameter int PRIO_MODE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              res_rd,
  output logic              res_wr,
  output logic [ADDR_W-1:0] res_addr,
  output logic [DATA_W-1:0] res_do,
  input  logic [DATA_W-1:0] res_di
);

  import dt_pkg::*;

  logic              acc;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  tag_t              sel_tag;
  tag_t              cmd_tag;

  dt_rr_arb2 #(
    .PRIO_MODE(PRIO_MODE)
  ) u_arb (
    .clk  (clk),
    .reset(reset),
    .a_req(a_req),
    .b_req(b_req),
    .a_gnt(a_gnt),
    .b_gnt(b_gnt)
  );

  always_comb begin
    acc       = a_gnt | b_gnt;
    sel_tag   = b_gnt ? TAG_B : TAG_A;
    sel_we    = b_gnt ? b_we : a_we;
    sel_addr  = b_gnt ? b_addr : a_addr;
    sel_wdata = b_gnt ? b_wdata : a_wdata;
  end

  // Command stage: strobes live for exactly one cycle, address/data hold otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_rd   <= 1'b0;
      res_wr   <= 1'b0;
      res_addr <= '0;
      res_do   <= '0;
      cmd_tag  <= TAG_A;
    end else begin
      res_rd <= acc & ~sel_we;
      res_wr <= acc & sel_we;
      if (acc) begin
        res_addr <= sel_addr;
        cmd_tag  <= sel_tag;
        if (sel_we) begin
          res_do <= sel_wdata;
        end
      end
    end
  end

  // res_rd doubles as the valid bit of the tag pipeline; data lands at the end of the command cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= res_rd & (cmd_tag == TAG_A);
      b_rvalid <= res_rd & (cmd_tag == TAG_B);
      if (res_rd && (cmd_tag == TAG_A)) begin
        a_rdata <= res_di;
      end
      if (res_rd && (cmd_tag == TAG_B)) begin
        b_rdata <= res_di;
      end
    end
  end

endmodule

// File: tb/tb_dt_res_arbiter.sv
// tb/tb_dt_res_arbiter.sv - scoreboard bench for the result-RAM arbiter
module tb_dt_res_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        a_req, a_we, b_req, b_we;
  logic [13:0] a_addr, b_addr;
  logic [7:0]  a_wdata, b_wdata;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [7:0]  a_rdata, b_rdata;
  logic        res_rd, res_wr;
  logic [13:0] res_addr;
  logic [7:0]  res_do, res_di;

  logic        p_a_req, p_a_we, p_b_req, p_b_we;
  logic [13:0] p_a_addr, p_b_addr;
  logic [7:0]  p_a_wdata, p_b_wdata;
  logic        p_a_gnt, p_b_gnt, p_a_rvalid, p_b_rvalid;
  logic [7:0]  p_a_rdata, p_b_rdata;
  logic        p_res_rd, p_res_wr;
  logic [13:0] p_res_addr;
  logic [7:0]  p_res_do;

  dt_res_arbiter #(.ADDR_W(14), .DATA_W(8), .PRIO_MODE(0)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .res_rd(res_rd), .res_wr(res_wr), .res_addr(res_addr), .res_do(res_do),
    .res_di(res_di)
  );

  dt_res_arbiter #(.ADDR_W(14), .DATA_W(8), .PRIO_MODE(1)) dut_prio (
    .clk(clk), .reset(reset),
    .a_req(p_a_req), .a_we(p_a_we), .a_addr(p_a_addr), .a_wdata(p_a_wdata),
    .a_gnt(p_a_gnt), .a_rvalid(p_a_rvalid), .a_rdata(p_a_rdata),
    .b_req(p_b_req), .b_we(p_b_we), .b_addr(p_b_addr), .b_wdata(p_b_wdata),
    .b_gnt(p_b_gnt), .b_rvalid(p_b_rvalid), .b_rdata(p_b_rdata),
    .res_rd(p_res_rd), .res_wr(p_res_wr), .res_addr(p_res_addr), .res_do(p_res_do),
    .res_di(8'h00)
  );

  // Result RAM: write at posedge, read at negedge of the command cycle.
  logic [7:0] mem [0:16383];
  always @(posedge clk) if (res_wr) mem[res_addr] <= res_do;
  always @(negedge clk) if (res_rd) res_di <= mem[res_addr];

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   rv_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (a_rvalid) begin
        rv_cnt++;
        if (qa.size() == 0) begin
          chk("a_rvalid_unexpected", a_rvalid, 0);
        end else begin
          ea = qa.pop_front();
          chk("a_rdata", a_rdata, ea.data);
          chk("a_rvalid_latency", cyc, ea.cyc);
        end
      end
      if (b_rvalid) begin
        rv_cnt++;
        if (qb.size() == 0) begin
          chk("b_rvalid_unexpected", b_rvalid, 0);
        end else begin
          eb = qb.pop_front();
          chk("b_rdata", b_rdata, eb.data);
          chk("b_rvalid_latency", cyc, eb.cyc);
        end
      end
    end
  end

  task automatic push_exp(input bit sel_b, input logic [7:0] d);
    exp_t e;
    e.data = d;
    e.cyc  = cyc + 2;
    if (sel_b) qb.push_back(e);
    else qa.push_back(e);
  endtask

  // Entered just after a posedge; returns just after the accept edge.
  task automatic access(input bit sel_b, input bit we, input logic [13:0] addr,
                        input logic [7:0] wd, input logic [7:0] rd_exp, output int lat);
    bit got;
    if (sel_b) begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
    end else begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
    end
    got = 1'b0;
    lat = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (sel_b ? b_gnt : a_gnt) begin
        got = 1'b1;
        lat = n;
        if (!we) push_exp(sel_b, rd_exp);
      end
    end
    chk(sel_b ? "b_gnt_timeout" : "a_gnt_timeout", got, 1);
    @(posedge clk); #1;
    if (sel_b) b_req = 1'b0;
    else a_req = 1'b0;
  endtask

  int lat, na, nb, rv_before;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout required=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    p_a_req = 0; p_a_we = 1; p_a_addr = 14'h0010; p_a_wdata = 8'h11;
    p_b_req = 0; p_b_we = 1; p_b_addr = 14'h0020; p_b_wdata = 8'h22;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("reset_outputs",
          {a_gnt, b_gnt, a_rvalid, b_rvalid, res_rd, res_wr, a_rdata, b_rdata, res_addr, res_do}, 0);
      chk("reset_outputs_prio", {p_a_gnt, p_b_gnt, p_res_rd, p_res_wr, p_res_addr}, 0);
    end
    @(posedge clk); #1;

    access(0, 1, 14'h0081, 8'h01, 8'h00, lat);
    chk("a_wr_gnt_same_cycle", lat, 0);
    @(negedge clk);
    chk("a_wr_cmd", {res_wr, res_rd, res_addr, res_do}, {1'b1, 1'b0, 14'h0081, 8'h01});
    @(posedge clk); #1;

    access(0, 0, 14'h0081, 8'h00, 8'h01, lat);
    @(negedge clk);
    chk("a_rd_cmd", {res_rd, res_wr, res_addr}, {1'b1, 1'b0, 14'h0081});
    repeat (3) @(posedge clk); #1;
    chk("a_rd_returned", qa.size(), 0);

    access(1, 1, 14'h0200, 8'hB2, 8'h00, lat);
    chk("b_wr_gnt_same_cycle", lat, 0);
    @(posedge clk); #1;

    a_req = 1; a_we = 0; a_addr = 14'h0081;
    b_req = 1; b_we = 0; b_addr = 14'h0200;
    na = 0; nb = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rr_a_gnt", a_gnt, (i % 2) == 0);
      chk("rr_b_gnt", b_gnt, (i % 2) == 1);
      if (a_gnt) begin na++; push_exp(0, 8'h01); end
      if (b_gnt) begin nb++; push_exp(1, 8'hB2); end
      @(posedge clk); #1;
    end
    a_req = 0; b_req = 0;
    chk("rr_a_count", na, 4);
    chk("rr_b_count", nb, 4);
    repeat (3) @(posedge clk); #1;
    chk("rr_reads_returned", qa.size() + qb.size(), 0);

    p_a_req = 1; p_b_req = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("prio_a_gnt", p_a_gnt, 1);
      chk("prio_b_gnt", p_b_gnt, 0);
      @(posedge clk); #1;
    end
    p_a_req = 0;
    @(negedge clk);
    chk("prio_b_after_a_drop", {p_a_gnt, p_b_gnt}, 2'b01);
    @(posedge clk); #1;
    p_b_req = 0;

    access(1, 1, 14'h3FFF, 8'h7F, 8'h00, lat);
    access(0, 0, 14'h3FFF, 8'h00, 8'h7F, lat);
    chk("raw_a_gnt_back_to_back", lat, 0);
    repeat (3) @(posedge clk); #1;
    chk("raw_returned", qa.size(), 0);

    access(0, 0, 14'h3FFF, 8'h00, 8'h7F, lat);
    chk("rst_mid_cmd_cycle", res_rd, 1);
    reset = 1'b0;
    qa.delete();
    qb.delete();
    rv_before = rv_cnt;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("no_rvalid_after_reset", rv_cnt - rv_before, 0);
    chk("rdata_cleared_by_reset", {a_rdata, res_rd, res_addr}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
